// File: rtl/mc_muldiv_pkg.sv
// Shared MIPS mult/div definitions: operation encodings, FSM state encoding,
// and the op decode helpers used by the mult/div controller.
package mc_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mc_muldiv.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle on operand magnitudes, sign fix-up afterwards.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   start, op, a, b   request; captured only on the accept edge in IDLE
//   busy, done        busy outside IDLE; done is a one-cycle result strobe
//   hi, lo            product high/low, or remainder/quotient
//   div_by_zero       last divide had a zero divisor
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | WIDTH iterations of shift-add or restoring divide
// ST_FIX  | sign correction / divide-by-zero override, results load
// ST_DONE | done strobe, results valid
module mc_muldiv
  import mc_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_CNT  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Operand magnitudes taken straight from the inputs at the accept edge.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = (op[0] && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign abs_b = (op[0] && b[WIDTH-1]) ? (~b + ONE_W) : b;

  // Shift-add step: add multiplicand into the upper half when the low bit
  // is set, then shift the whole accumulator right keeping the carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: partial remainder shifted left needs WIDTH+1 bits;
  // borrow out of the trial subtract means "does not fit".
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic               neg_res;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg, rem_neg;
  assign neg_res  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign prod_neg = ~acc_q + ONE_2W;
  assign quot_neg = ~acc_q[WIDTH-1:0] + ONE_W;
  assign rem_neg  = ~acc_q[2*WIDTH-1:WIDTH] + ONE_W;

  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             fix_dbz;
  always_comb begin
    fix_hi  = acc_q[2*WIDTH-1:WIDTH];
    fix_lo  = acc_q[WIDTH-1:0];
    fix_dbz = 1'b0;
    if (op_is_div(op_q)) begin
      if (b_q == '0) begin
        fix_dbz = 1'b1;
        fix_hi  = a_q;
        fix_lo  = '1;
      end else if (op_is_signed(op_q)) begin
        if (neg_res)      fix_lo = quot_neg;
        if (a_q[WIDTH-1]) fix_hi = rem_neg;
      end
    end else if (op_is_signed(op_q) && neg_res) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    opb_d = opb_q;
    acc_d = acc_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    dbz_d = dbz_q;
    case (state_q)
      ST_IDLE: if (start) begin
        cnt_d = '0;
        op_d  = md_op_e'(op);
        a_d   = a;
        b_d   = b;
        opb_d = abs_b;
        acc_d = {{WIDTH{1'b0}}, abs_a};
      end
      ST_RUN: begin
        cnt_d = cnt_q + ONE_CNT;
        acc_d = op_is_div(op_q) ? div_next : mul_next;
      end
      ST_FIX: begin
        hi_d  = fix_hi;
        lo_d  = fix_lo;
        dbz_d = fix_dbz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= OP_MULTU;
      a_q   <= '0;
      b_q   <= '0;
      opb_q <= '0;
      acc_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      opb_q <= opb_d;
      acc_q <= acc_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dbz_q <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mc_muldiv.sv
// Testbench for mc_muldiv at WIDTH=32: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mc_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mc_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // MIPS HI/LO semantics from 64-bit integer arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] ia, ib,
                                    output logic [31:0] ehi, elo, output logic edbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    edbz = 1'b0;
    ehi  = '0;
    elo  = '0;
    sa = $signed(ia);
    sb = $signed(ib);
    case (o)
      2'd0: begin p = {32'h0, ia} * {32'h0, ib}; ehi = p[63:32]; elo = p[31:0]; end
      2'd1: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
      default: begin
        if (ib == 32'h0) begin
          edbz = 1'b1; ehi = ia; elo = 32'hFFFFFFFF;
        end else if (o == 2'd2) begin
          elo = ia / ib; ehi = ia % ib;
        end else begin
          q = sa / sb; r = sa % sb;
          elo = q[31:0]; ehi = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; drives one request, scrambles inputs after the
  // accept edge, and observes 40 cycles. lat = cycle index of first done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] ia, ib,
                       output int lat, output int ndone,
                       output logic [31:0] ohi, olo, output logic odbz);
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk);
    lat = -1; ndone = 0; ohi = '0; olo = '0; odbz = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom); end
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = n; ohi = hi; olo = lo; odbz = div_by_zero; end
      end
    end
  endtask

  task automatic test_reset();
    int lat, nd; logic [31:0] rh, rl; logic rd;
    reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
    reset = 1'b0;
    do_op(2'd0, 32'd7, 32'd9, lat, nd, rh, rl, rd);
    checks++; if (lat !== 34) begin errors++; $display("FAIL first_start_lat got %0d want 34", lat); end
    checks++; if (rl !== 32'd63 || rh !== 32'd0) begin errors++; $display("FAIL first_start_res got %h_%h want 0_3f", rh, rl); end
  endtask

  task automatic test_directed();
    int lat, nd; logic [31:0] rh, rl; logic rd;
    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nd, rh, rl, rd);
    checks++; if (rh !== 32'hFFFFFFFE || rl !== 32'h1) begin errors++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", rh, rl); end
    checks++; if (lat !== 34 || nd !== 1) begin errors++; $display("FAIL multu_max_lat got lat %0d n %0d want 34 1", lat, nd); end
    do_op(2'd1, 32'hFFFFFFFD, 32'd7, lat, nd, rh, rl, rd);
    checks++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg got %h_%h want ffffffff_ffffffeb", rh, rl); end
    do_op(2'd3, 32'hFFFFFFF9, 32'd2, lat, nd, rh, rl, rd);
    checks++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", rh, rl); end
    do_op(2'd2, 32'd100, 32'd0, lat, nd, rh, rl, rd);
    checks++; if (rd !== 1'b1 || rl !== 32'hFFFFFFFF || rh !== 32'h64) begin errors++; $display("FAIL divu_zero got dbz %b %h_%h want 1 00000064_ffffffff", rd, rh, rl); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_zero_lat got %0d want 34", lat); end
    do_op(2'd0, 32'd2, 32'd3, lat, nd, rh, rl, rd);
    checks++; if (rd !== 1'b0 || rl !== 32'd6 || rh !== 32'd0) begin errors++; $display("FAIL multu_after_dbz got dbz %b %h_%h want 0 0_6", rd, rh, rl); end
    do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, lat, nd, rh, rl, rd);
    checks++; if (rd !== 1'b0 || rl !== 32'h80000000 || rh !== 32'h0) begin errors++; $display("FAIL div_overflow got dbz %b %h_%h want 0 0_80000000", rd, rh, rl); end
  endtask

  task automatic test_random();
    int lat, nd; logic [31:0] rh, rl, eh, el, ra, rb; logic rd, ed; logic [1:0] ro;
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom); ra = pick(); rb = pick();
      ref_model(ro, ra, rb, eh, el, ed);
      do_op(ro, ra, rb, lat, nd, rh, rl, rd);
      checks++; if (lat !== 34 || nd !== 1) begin errors++; $display("FAIL rand_timing[%0d] got lat %0d n %0d want 34 1", i, lat, nd); end
      checks++; if (rh !== eh || rl !== el || rd !== ed) begin errors++;
        $display("FAIL rand_result[%0d] op %0d a %h b %h got %h_%h dbz %b want %h_%h dbz %b", i, ro, ra, rb, rh, rl, rd, eh, el, ed); end
    end
  endtask

  task automatic test_hold_inputs();
    int lat, nd; logic [31:0] rh, rl, ph, pl, eh, el; logic rd, ed;
    do_op(2'd0, 32'h12345678, 32'h9ABCDEF0, lat, nd, ph, pl, rd);
    ref_model(2'd1, 32'hFFFF0001, 32'h00012345, eh, el, ed);
    start = 1'b1; op = 2'd1; a = 32'hFFFF0001; b = 32'h00012345;
    @(posedge clk);
    nd = 0; rh = '0; rl = '0; rd = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 20) begin
        checks++; if (hi !== ph || lo !== pl) begin errors++; $display("FAIL hold_midrun got %h_%h want %h_%h", hi, lo, ph, pl); end
      end
      if (done) begin nd++; rh = hi; rl = lo; rd = div_by_zero; start = 1'b0; end
      else if (start) begin a = $urandom; b = $urandom; op = 2'($urandom); end
    end
    start = 1'b0;
    checks++; if (nd !== 1) begin errors++; $display("FAIL hold_done_count got %0d want 1", nd); end
    checks++; if (rh !== eh || rl !== el || rd !== ed) begin errors++; $display("FAIL hold_result got %h_%h want %h_%h", rh, rl, eh, el); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nd; logic [31:0] h1, l1, h2, l2, e1h, e1l, e2h, e2l; logic ed;
    ref_model(2'd2, 32'd1000, 32'd7, e1h, e1l, ed);
    ref_model(2'd1, 32'h80000000, 32'h80000000, e2h, e2l, ed);
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    d1 = -1; d2 = -1; nd = 0; h1 = '0; l1 = '0; h2 = '0; l2 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; a = 32'd5; b = 32'd5; op = 2'd0; end
      if (done) begin
        nd++;
        if (d1 < 0) begin d1 = n; h1 = hi; l1 = lo; end
        else if (d2 < 0) begin d2 = n; h2 = hi; l2 = lo; end
      end
      if (n == 34) begin start = 1'b1; op = 2'd1; a = 32'h80000000; b = 32'h80000000; end
      if (n == 35) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy got %b want 0", busy); end
      end
      if (n == 36) begin start = 1'b0; a = 32'd1; b = 32'd1; op = 2'd0; end
    end
    checks++; if (d1 !== 34 || d2 !== 69 || nd !== 2) begin errors++; $display("FAIL b2b_timing got %0d %0d n %0d want 34 69 2", d1, d2, nd); end
    checks++; if (h1 !== e1h || l1 !== e1l) begin errors++; $display("FAIL b2b_first got %h_%h want %h_%h", h1, l1, e1h, e1l); end
    checks++; if (h2 !== e2h || l2 !== e2l) begin errors++; $display("FAIL b2b_second got %h_%h want %h_%h", h2, l2, e2h, e2l); end
  endtask

  task automatic test_reset_midop();
    int lat, nd; logic [31:0] rh, rl, eh, el; logic rd, ed;
    do_op(2'd0, 32'hFFFFFFFF, 32'd3, lat, nd, rh, rl, rd);
    checks++; if (rh !== 32'd2 || rl !== 32'hFFFFFFFD) begin errors++; $display("FAIL pre_reset_res got %h_%h want 2_fffffffd", rh, rl); end
    start = 1'b1; op = 2'd1; a = 32'hDEADBEEF; b = 32'h00C0FFEE;
    @(posedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midop_reset_ctl got busy %b done %b want 0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL midop_reset_res got %h_%h dbz %b want 0", hi, lo, div_by_zero); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midop_no_done got %0d active cycles want 0", nd); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midop_no_partial got %h_%h want 0", hi, lo); end
    ref_model(2'd3, 32'hFFFFF000, 32'd10, eh, el, ed);
    do_op(2'd3, 32'hFFFFF000, 32'd10, lat, nd, rh, rl, rd);
    checks++; if (lat !== 34 || rh !== eh || rl !== el || rd !== ed) begin errors++; $display("FAIL after_reset_op got lat %0d %h_%h want 34 %h_%h", lat, rh, rl, eh, el); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_inputs();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_muldiv.md
MC_MULDIV -- requirements
Module: mc_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; hi, lo and div_by_zero are valid while it is high.
REQ-010 SHALL have port hi  output  WIDTH  product upper half, or remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half, or quotient.
REQ-012 SHALL have port div_by_zero  output  1  last divide had b == 0.

Function
REQ-013 SHALL implement a four-state FSM with states IDLE, RUN, FIX and DONE, with these transitions:
- IDLE -> RUN on a clock edge where start=1 (the accept edge).
- RUN -> FIX after exactly WIDTH edges in RUN.
- FIX -> DONE after one edge.
- DONE -> IDLE after one edge.
REQ-014 SHALL capture op, a and b only at the accept edge; later changes to the inputs SHALL have no effect on the operation in flight.
REQ-015 SHALL ignore start whenever busy=1; there is no queueing and no restart.
REQ-016 SHALL, for signed ops, take the absolute values of the operands at the accept edge and run the unsigned iteration on those values.
REQ-017 SHALL compute multiply by shift-add, one iteration per RUN cycle, into a 2*WIDTH-bit accumulator.
REQ-018 SHALL compute divide by restoring division, one quotient bit per RUN cycle.
REQ-019 SHALL apply the sign correction in FIX:
- MULT result negated when a[MSB] ^ b[MSB].
- DIV quotient negated when a[MSB] ^ b[MSB].
- DIV remainder takes the sign of a.
REQ-020 SHALL write hi, lo and div_by_zero on the FIX->DONE edge only; at all other times they hold their last values.
REQ-021 SHALL assert done only in DONE, for exactly one cycle, which is WIDTH+2 cycles after the accept edge; busy SHALL be 1 in RUN, FIX and DONE.
REQ-022 SHALL handle a divide with b == 0 (DIVU or DIV) as follows, with unchanged latency: div_by_zero=1, lo = all ones, hi = a as captured.
REQ-023 SHALL handle DIV with a = most-negative and b = -1 as follows, with no special flag: lo = most-negative (wrapped), hi = 0.
REQ-024 SHALL set div_by_zero=0 for every multiply and for every divide with a non-zero divisor.
REQ-025 SHALL make a new start legal in the cycle after DONE, giving back-to-back throughput of one result every WIDTH+3 cycles.
REQ-026 SHALL size the iteration counter as $clog2(WIDTH)+1 bits and clear it on the accept edge.

Reset
REQ-027 SHALL, while reset=1 and regardless of clk, force state=IDLE, busy=0, done=0, hi=0, lo=0 and div_by_zero=0, and clear the counter and accumulator.
REQ-028 SHALL abandon an operation in flight when reset is asserted mid-operation, with no partial result ever appearing on hi or lo.
REQ-029 SHALL accept the first start on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take the op encodings (MULTU, MULT, DIVU, DIV) and the FSM state encoding from the shared MIPS package; the controller decode for mult/div uses the same package.
REQ-031 SHALL be a single module with no sub-module; the negate and absolute-value logic is local combinational logic.

Verification
REQ-032 SHALL cover these directed scenarios (all at WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 cycles after the accept edge.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=0x00000064; a following MULTU 2*3 -> div_by_zero=0, lo=6.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- start held high and a/b toggled every cycle during RUN -> exactly one done, with the result of the operands captured at the accept edge.
- reset pulsed at RUN cycle 10 -> busy=0, hi=lo=0 with no clock edge; no done pulse; a start after reset yields the correct result.
